alu_arbiter: RTL and testbench

Shares the single ALU between NREQ requesters (e.g. execute stage and branch/address unit) with round-robin arbitration and valid/ready handshakes. Holds one operation in flight: captures the granted request, drives the ALU from registers for one cycle, registers the result and returns it to the owning requester. The ALU remains purely combinational; this block is its only driver.

---
 rtl/alu_arbiter_pkg.sv | 32 +++
 rtl/alu_arbiter_if.sv | 37 +++
 rtl/alu_arbiter_rr.sv | 38 +++
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode constants, FSM state type and opcode legality helper
//            shared by the ALU arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [5:0] ALU_ADD    = 6'd0;
  localparam logic [5:0] ALU_SUB    = 6'd1;
  localparam logic [5:0] ALU_AND    = 6'd2;
  localparam logic [5:0] ALU_OR     = 6'd3;
  localparam logic [5:0] ALU_SLL    = 6'd4;
  localparam logic [5:0] ALU_SRL    = 6'd5;
  localparam logic [5:0] ALU_SLT    = 6'd6;
  localparam logic [5:0] ALU_SLTU   = 6'd7;
  localparam logic [5:0] ALU_OP_MAX = 6'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Anything above the last defined opcode is rejected without touching the ALU.
  function automatic logic is_legal_op(input logic [5:0] sel);
    return (sel <= ALU_OP_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Request/response handshake bundle between the requesters and
//            the ALU arbiter. Operands and opcodes are packed per requester.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int NREQ = 2,
  parameter int W    = 32
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*6-1:0] req_sel;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_result;
  logic              rsp_zero;
  logic              rsp_err;

  // Requester side
  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker. Search starts one past the
//            last granted index and wraps; the pointer itself is held by the
//            caller so it only advances on an actual accept.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_last,
  output logic [NREQ-1:0] o_grant,
  output logic [IDXW-1:0] o_grant_idx
);

  logic w_found;

  // First requesting index at or after last+1 (mod NREQ) wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(i_last) + k) % NREQ;
      if (!w_found && i_req[idx]) begin
        w_found          = 1'b1;
        o_grant[idx]     = 1'b1;
        o_grant_idx      = IDXW'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one combinational ALU between NREQ requesters. One op in
//            flight: accept (IDLE) -> drive ALU from registers (EXEC) ->
//            hold registered result until the owner takes it (RESP).
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [5:0]        alu_sel,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_zero,
  output logic              busy,
  output logic [15:0]       op_count
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          r_state;
  state_t          w_next_state;
  logic [IDXW-1:0] r_last;
  logic [IDXW-1:0] r_id;
  logic            r_illegal;
  logic [W-1:0]    r_alu_a;
  logic [W-1:0]    r_alu_b;
  logic [5:0]      r_alu_sel;
  logic [W-1:0]    r_result;
  logic            r_zero;
  logic            r_err;
  logic [15:0]     r_op_count;

  logic [NREQ-1:0] w_grant;
  logic [IDXW-1:0] w_grant_idx;
  logic [W-1:0]    w_req_a;
  logic [W-1:0]    w_req_b;
  logic [5:0]      w_req_sel;
  logic            w_legal;
  logic            w_accept;
  logic            w_rsp_hs;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_arbiter (
    .i_req       (bus.req_valid),
    .i_last      (r_last),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign w_req_a   = bus.req_a[int'(w_grant_idx)*W +: W];
  assign w_req_b   = bus.req_b[int'(w_grant_idx)*W +: W];
  assign w_req_sel = bus.req_sel[int'(w_grant_idx)*6 +: 6];
  assign w_legal   = is_legal_op(w_req_sel);
  // The grant is a subset of req_valid, so any grant in IDLE is an accept.
  assign w_accept  = (r_state == IDLE) && (|w_grant);
  assign w_rsp_hs  = (r_state == RESP) && bus.rsp_ready[r_id];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state: accept -> one ALU cycle -> wait for the owner's handshake
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = EXEC;
      EXEC:    w_next_state = RESP;
      RESP:    if (w_rsp_hs) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs; gated by rst_n so nothing is offered during reset
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    busy          = (r_state != IDLE);
    if (rst_n) begin
      if (r_state == IDLE) bus.req_ready = w_grant;
      if (r_state == RESP) bus.rsp_valid[r_id] = 1'b1;
    end
  end

  // Capture owner, legality and advance the round-robin pointer on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last    <= IDXW'(NREQ - 1);
      r_id      <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_last    <= w_grant_idx;
      r_id      <= w_grant_idx;
      r_illegal <= !w_legal;
    end
  end

  // ALU drive registers: valid only during EXEC, held at 0 for illegal ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
    end else if (w_accept) begin
      r_alu_a   <= w_legal ? w_req_a   : '0;
      r_alu_b   <= w_legal ? w_req_b   : '0;
      r_alu_sel <= w_legal ? w_req_sel : '0;
    end else if (r_state == EXEC) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
    end
  end

  // Register the ALU result at the end of EXEC; held until the next op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else if (r_state == EXEC) begin
      r_result <= r_illegal ? '0 : alu_out;
      r_zero   <= alu_zero;
      r_err    <= r_illegal;
    end
  end

  // Count legal operations at their response handshake; wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_op_count <= '0;
    else if (w_rsp_hs && !r_illegal) r_op_count <= r_op_count + 16'd1;
  end

  assign alu_a          = r_alu_a;
  assign alu_b          = r_alu_b;
  assign alu_sel        = r_alu_sel;
  assign bus.rsp_result = r_result;
  assign bus.rsp_zero   = r_zero;
  assign bus.rsp_err    = r_err;
  assign op_count       = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter with a behavioural ALU and a
//            transaction-level round-robin / result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 32;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  alu_a, alu_b, alu_out;
  logic [5:0]    alu_sel;
  logic          alu_zero, busy;
  logic [15:0]   op_count;

  int n_pass  = 0;
  int n_total = 0;
  int m_last  = NREQ - 1;
  int m_ops   = 0;

  alu_arbiter_if #(.NREQ(NREQ), .W(W)) arb_bus ();

  alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (arb_bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .alu_zero (alu_zero),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // Reference arithmetic for the eight opcodes.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] sel);
    case (sel)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  // External ALU stand-in; an illegal select yields a poison value.
  always_comb begin
    alu_out  = (alu_sel > ALU_OP_MAX) ? 32'hDEAD_BEEF : ref_alu(alu_a, alu_b, alu_sel);
    alu_zero = (alu_a == alu_b);
  end

  // Round-robin model: first valid requester after the last grant.
  function automatic int rr_pick(input logic [NREQ-1:0] valid);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_last + k) % NREQ;
      if (valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] sel);
    arb_bus.req_valid[id]       = 1'b1;
    arb_bus.req_a[id*W +: W]    = a;
    arb_bus.req_b[id*W +: W]    = b;
    arb_bus.req_sel[id*6 +: 6]  = sel;
  endtask

  // Called in the EXEC cycle. Returns cycles until rsp_valid (-1 on timeout),
  // then holds off rsp_ready for 'delay' cycles (unless early) and handshakes.
  task automatic wait_rsp(input int id, input int delay, input bit early, output int lat,
                          output logic [31:0] res, output logic z, output logic e);
    lat = -1;
    res = 'x; z = 1'bx; e = 1'bx;
    if (early) arb_bus.rsp_ready[id] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (arb_bus.rsp_valid[id]) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) begin
      arb_bus.rsp_ready[id] = 1'b0;
      return;
    end
    if (!early) repeat (delay) tick();
    res = arb_bus.rsp_result;
    z   = arb_bus.rsp_zero;
    e   = arb_bus.rsp_err;
    arb_bus.rsp_ready[id] = 1'b1;
    tick();
    arb_bus.rsp_ready[id] = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n  = 1'b1;
    m_last = NREQ - 1;
    m_ops  = 0;
    tick();
  endtask

  task automatic test_reset();
    arb_bus.req_valid = '1;
    arb_bus.rsp_ready = '1;
    repeat (2) tick();
    n_total++; if (arb_bus.req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", arb_bus.req_ready); else n_pass++;
    n_total++; if (arb_bus.rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b want 00", arb_bus.rsp_valid); else n_pass++;
    n_total++; if ({busy, op_count, alu_sel} !== 23'd0) $display("FAIL reset_state: busy=%b op_count=%0h alu_sel=%0h want 0", busy, op_count, alu_sel); else n_pass++;
    n_total++; if ({alu_a, alu_b, arb_bus.rsp_result, arb_bus.rsp_zero, arb_bus.rsp_err} !== 98'd0) $display("FAIL reset_data: alu_a=%0h alu_b=%0h result=%0h want 0", alu_a, alu_b, arb_bus.rsp_result); else n_pass++;
    arb_bus.rsp_ready = '0;
    rst_n = 1'b1;
    #1;
    n_total++; if (arb_bus.req_ready !== 2'b01) $display("FAIL reset_first_grant: got %b want 01", arb_bus.req_ready); else n_pass++;
    arb_bus.req_valid = '0;
    tick();
  endtask

  task automatic test_single_op();
    int lat; logic [31:0] res; logic z, e;
    drive_req(0, 32'd5, 32'd3, ALU_ADD);
    #1;
    n_total++; if (arb_bus.req_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", arb_bus.req_ready); else n_pass++;
    tick();
    arb_bus.req_valid[0] = 1'b0; m_last = 0;
    n_total++; if ({alu_a, alu_b, alu_sel} !== {32'd5, 32'd3, ALU_ADD}) $display("FAIL single_exec_drive: got a=%0h b=%0h sel=%0h want 5 3 0", alu_a, alu_b, alu_sel); else n_pass++;
    n_total++; if ({busy, arb_bus.req_ready} !== 3'b100) $display("FAIL single_exec_busy: got busy=%b ready=%b want 1 00", busy, arb_bus.req_ready); else n_pass++;
    wait_rsp(0, 0, 1'b0, lat, res, z, e);
    m_ops++;
    n_total++; if (lat !== 1) $display("FAIL single_latency: got %0d want 1", lat); else n_pass++;
    n_total++; if ({res, z, e} !== {32'd8, 1'b0, 1'b0}) $display("FAIL single_result: got %0h z=%b e=%b want 8 0 0", res, z, e); else n_pass++;
    n_total++; if (op_count !== 16'd1) $display("FAIL single_op_count: got %0d want 1", op_count); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_contention();
    int lat; logic [31:0] res; logic z, e;
    apply_reset();
    drive_req(0, 32'd7, 32'd7, ALU_SUB);
    drive_req(1, 32'd2, 32'd9, ALU_SLT);
    #1;
    n_total++; if (arb_bus.req_ready !== 2'b01) $display("FAIL contend_first: got %b want 01", arb_bus.req_ready); else n_pass++;
    tick();
    arb_bus.req_valid[0] = 1'b0; m_last = 0;
    wait_rsp(0, 1, 1'b0, lat, res, z, e);
    m_ops++;
    n_total++; if ({res, z, e} !== {32'd0, 1'b1, 1'b0}) $display("FAIL contend_req0: got %0h z=%b e=%b want 0 1 0", res, z, e); else n_pass++;
    n_total++; if (arb_bus.req_ready !== 2'b10) $display("FAIL contend_second: got %b want 10", arb_bus.req_ready); else n_pass++;
    tick();
    arb_bus.req_valid[1] = 1'b0; m_last = 1;
    wait_rsp(1, 0, 1'b1, lat, res, z, e);
    m_ops++;
    n_total++; if ({lat, res, z, e} !== {32'd1, 32'd1, 1'b0, 1'b0}) $display("FAIL contend_req1: got lat=%0d %0h z=%b e=%b want 1 1 0 0", lat, res, z, e); else n_pass++;
    n_total++; if (op_count !== 16'(m_ops)) $display("FAIL contend_count: got %0d want %0d", op_count, m_ops); else n_pass++;
    drive_req(0, 32'd7, 32'd7, ALU_SUB);
    drive_req(1, 32'd2, 32'd9, ALU_SLT);
    #1;
    n_total++; if (arb_bus.req_ready !== 2'b01) $display("FAIL contend_reissue: got %b want 01", arb_bus.req_ready); else n_pass++;
    arb_bus.req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] res; logic z, e;
    drive_req(0, 32'd100, 32'd23, ALU_ADD);
    drive_req(1, 32'hF0, 32'h0F, ALU_OR);
    #1;
    n_total++; if (arb_bus.req_ready !== 2'b01) $display("FAIL bp_grant0: got %b want 01", arb_bus.req_ready); else n_pass++;
    tick();
    arb_bus.req_valid[0] = 1'b0; m_last = 0;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_total++; if ({arb_bus.rsp_valid, arb_bus.rsp_result, busy, arb_bus.req_ready} !== {2'b01, 32'd123, 1'b1, 2'b00})
        $display("FAIL bp_hold_%0d: got valid=%b result=%0d busy=%b ready=%b want 01 123 1 00", k, arb_bus.rsp_valid, arb_bus.rsp_result, busy, arb_bus.req_ready);
      else n_pass++;
      if (k < 3) tick();
    end
    arb_bus.rsp_ready[0] = 1'b1;
    tick();
    arb_bus.rsp_ready[0] = 1'b0;
    m_ops++;
    n_total++; if (arb_bus.req_ready !== 2'b10) $display("FAIL bp_next_grant: got %b want 10", arb_bus.req_ready); else n_pass++;
    tick();
    arb_bus.req_valid[1] = 1'b0; m_last = 1;
    wait_rsp(1, 0, 1'b0, lat, res, z, e);
    m_ops++;
    n_total++; if ({res, e} !== {32'hFF, 1'b0}) $display("FAIL bp_req1_result: got %0h e=%b want ff 0", res, e); else n_pass++;
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] res; logic z, e;
    drive_req(0, 32'd4, 32'd4, 6'd9);
    #1;
    n_total++; if (arb_bus.req_ready !== 2'b01) $display("FAIL illegal_grant: got %b want 01", arb_bus.req_ready); else n_pass++;
    tick();
    arb_bus.req_valid[0] = 1'b0; m_last = 0;
    n_total++; if ({alu_a, alu_b, alu_sel} !== 70'd0) $display("FAIL illegal_alu_drive: got a=%0h b=%0h sel=%0h want 0", alu_a, alu_b, alu_sel); else n_pass++;
    wait_rsp(0, 0, 1'b0, lat, res, z, e);
    n_total++; if ({res, e} !== {32'd0, 1'b1}) $display("FAIL illegal_result: got %0h e=%b want 0 1", res, e); else n_pass++;
    n_total++; if (op_count !== 16'(m_ops)) $display("FAIL illegal_count: got %0d want %0d", op_count, m_ops); else n_pass++;
  endtask

  task automatic test_shift();
    int lat; logic [31:0] res; logic z, e;
    drive_req(1, 32'd1, 32'd4, ALU_SLL);
    #1;
    n_total++; if (arb_bus.req_ready !== 2'b10) $display("FAIL shift_grant1: got %b want 10", arb_bus.req_ready); else n_pass++;
    tick();
    arb_bus.req_valid[1] = 1'b0; m_last = 1;
    wait_rsp(1, 0, 1'b0, lat, res, z, e);
    m_ops++;
    n_total++; if (res !== 32'd16) $display("FAIL shift_sll: got %0h want 10", res); else n_pass++;
    drive_req(0, 32'h8000_0000, 32'd31, ALU_SRL);
    tick();
    arb_bus.req_valid[0] = 1'b0; m_last = 0;
    wait_rsp(0, 2, 1'b0, lat, res, z, e);
    m_ops++;
    n_total++; if (res !== 32'd1) $display("FAIL shift_srl: got %0h want 1", res); else n_pass++;
    n_total++; if (op_count !== 16'(m_ops)) $display("FAIL shift_count: got %0d want %0d", op_count, m_ops); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0]     pa [NREQ];
    logic [31:0]     pb [NREQ];
    logic [5:0]      ps [NREQ];
    logic [NREQ-1:0] pv;
    logic [NREQ-1:0] exp_rdy;
    logic [31:0]     exp_res, res;
    logic            legal, z, e;
    int              id, lat;
    pv = '0;
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && ($urandom_range(0, 1) == 1)) begin
          pv[i] = 1'b1;
          pa[i] = $urandom;
          pb[i] = ($urandom_range(0, 3) == 0) ? pa[i] : $urandom;
          ps[i] = 6'($urandom_range(0, 9));
        end
      end
      if (pv == '0) begin
        id = $urandom_range(0, NREQ - 1);
        pv[id] = 1'b1; pa[id] = $urandom; pb[id] = $urandom; ps[id] = ALU_SLTU;
      end
      for (int i = 0; i < NREQ; i++) if (pv[i]) drive_req(i, pa[i], pb[i], ps[i]);
      #1;
      id = rr_pick(pv);
      exp_rdy = '0; exp_rdy[id] = 1'b1;
      n_total++; if (arb_bus.req_ready !== exp_rdy) $display("FAIL rand_grant_%0d: got %b want %b", it, arb_bus.req_ready, exp_rdy); else n_pass++;
      tick();
      m_last = id;
      pv[id] = 1'b0;
      arb_bus.req_valid[id] = 1'b0;
      arb_bus.req_a[id*W +: W] = $urandom;
      legal   = (ps[id] <= 6'd7);
      exp_res = legal ? ref_alu(pa[id], pb[id], ps[id]) : 32'd0;
      wait_rsp(id, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), lat, res, z, e);
      if (legal) m_ops++;
      n_total++; if ({lat, res, e} !== {32'd1, exp_res, !legal}) $display("FAIL rand_rsp_%0d: got lat=%0d %0h e=%b want 1 %0h %b", it, lat, res, e, exp_res, !legal); else n_pass++;
      if (legal) begin
        n_total++; if (z !== (pa[id] == pb[id])) $display("FAIL rand_zero_%0d: got %b want %b", it, z, (pa[id] == pb[id])); else n_pass++;
      end
      n_total++; if (op_count !== 16'(m_ops)) $display("FAIL rand_count_%0d: got %0d want %0d", it, op_count, m_ops); else n_pass++;
    end
    arb_bus.req_valid = '0;
  endtask

  task automatic test_reset_midop();
    drive_req(0, 32'd11, 32'd22, ALU_ADD);
    tick();
    arb_bus.req_valid[0] = 1'b0;
    tick();
    n_total++; if (arb_bus.rsp_valid !== 2'b01) $display("FAIL rstmid_in_resp: got %b want 01", arb_bus.rsp_valid); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if ({arb_bus.rsp_valid, busy, op_count} !== 19'd0) $display("FAIL rstmid_drop: got valid=%b busy=%b op_count=%0d want 0", arb_bus.rsp_valid, busy, op_count); else n_pass++;
    arb_bus.req_valid = '1;
    drive_req(0, 32'd1, 32'd1, ALU_AND);
    drive_req(1, 32'd1, 32'd1, ALU_AND);
    #1;
    n_total++; if (arb_bus.req_ready !== 2'b00) $display("FAIL rstmid_ready_gated: got %b want 00", arb_bus.req_ready); else n_pass++;
    tick();
    rst_n = 1'b1; m_last = NREQ - 1; m_ops = 0;
    #1;
    n_total++; if (arb_bus.req_ready !== 2'b01) $display("FAIL rstmid_regrant: got %b want 01", arb_bus.req_ready); else n_pass++;
    n_total++; if (op_count !== 16'd0) $display("FAIL rstmid_count: got %0d want 0", op_count); else n_pass++;
    arb_bus.req_valid = '0;
    tick();
  endtask

  initial begin
    arb_bus.req_valid = '0;
    arb_bus.req_a     = '0;
    arb_bus.req_b     = '0;
    arb_bus.req_sel   = '0;
    arb_bus.rsp_ready = '0;
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_illegal();
    test_shift();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
